// File: rtl/bip_pkg.sv
// bip_pkg: definitions shared across the BIP core.
//   state_t     - data-memory sequencer states (clear sweep / normal run)
//   RDW_OLD/NEW - same-address read-during-write behaviour selectors
//   BIP_*       - default word and address widths used by the core top level
package bip_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;  // read returns the word before the write
  localparam int RDW_NEW = 1;  // read returns the word being written

  localparam int BIP_DATA_W = 16;
  localparam int BIP_ADDR_W = 11;

endpackage

// File: rtl/bip_dmem_if.sv
// bip_dmem_if: access bus between the load/store unit (master) and the
// data memory (slave).
//   wr_en_i/wr_addr_i/wr_data_i - write port
//   rd_en_i/rd_addr_i           - read request port
//   rd_valid_o/rd_data_o        - read result port
//   ready_o/busy_o              - memory status
//
// Handshake: a strobe (wr_en_i or rd_en_i) is taken at a rising edge only
// when ready_o is high at that edge; strobes while ready_o is low are
// dropped, not queued. Results have no backpressure: rd_valid_o is high for
// exactly one cycle per accepted read and the consumer must take rd_data_o
// in that cycle. rd_data_o holds the last delivered word while rd_valid_o
// is low.
interface bip_dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              ready_o;
  logic              busy_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    input  rd_valid_o, rd_data_o, ready_o, busy_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    output rd_valid_o, rd_data_o, ready_o, busy_o
  );
endinterface

// File: rtl/bip_ram_pipe.sv
// bip_ram_pipe: {valid, data} delay line of STAGES registers used to stretch
// the memory read latency. Only the valid bits are reset so in-flight reads
// are dropped by reset; the data registers are plain delay flops.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   i_valid/i_data - entry of the line
//   o_valid/o_data - exit of the line (STAGES cycles later; wire-through
//                    when STAGES == 0)
module bip_ram_pipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  if (STAGES == 0) begin : g_wire
    assign o_valid = i_valid;
    assign o_data  = i_data;

    // Clock and reset have no load in the zero-stage case.
    logic w_unused;
    assign w_unused = ^{clk_i, rst_i};
  end else begin : g_regs
    logic [STAGES-1:0] r_valid;
    logic [DATA_W-1:0] r_data [STAGES];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= i_valid;
        for (int s = 1; s < STAGES; s++) begin
          r_valid[s] <= r_valid[s-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      r_data[0] <= i_data;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s] <= r_data[s-1];
      end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_data  = r_data[STAGES-1];
  end

endmodule

// File: rtl/bip_dmem.sv
// bip_dmem: simple dual-port data memory for the BIP core (one write port,
// one read port, one clock) with configurable read latency, defined
// same-address read/write ordering and an optional post-reset zero sweep.
//   clk_i       - clock
//   rst_i       - synchronous active-high reset
//   bus         - bip_dmem_if slave: write port, read port, read result,
//                 ready_o (accepting accesses) and busy_o (sweep running)
//   dbg_state_o - current sequencer state
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), READ_LAT (1..3),
// RDW_MODE (RDW_OLD / RDW_NEW), CLEAR_ON_RESET (0/1).
// DATA_W/ADDR_W must match the parameters of the connected interface.
module bip_dmem
  import bip_pkg::*;
#(
  parameter int DATA_W         = BIP_DATA_W,
  parameter int ADDR_W         = BIP_ADDR_W,
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  bip_dmem_if.slave  bus,
  output state_t     dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("bip_dmem: READ_LAT must be 1..3");
  end

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;
  logic              w_ready;
  logic              w_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_ready        = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy = 1'b1;
        // The counter stops on all-ones; the last zero write happens in
        // this same cycle, so RUN starts on the following edge.
        if (r_clr_cnt == CLR_LAST) begin
          w_state_next = ST_RUN;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  assign dbg_state_o = r_state;
  assign bus.ready_o = w_ready;
  assign bus.busy_o  = w_busy;

  // ---------------------------------------------------------------------
  // Storage array and write port
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_accept;
  logic              w_rd_accept;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Accesses are gated by rst_i as well as the state so nothing lands in
  // the array or the read pipe at a reset edge.
  assign w_wr_accept = !rst_i && (r_state == ST_RUN) && bus.wr_en_i;
  assign w_rd_accept = !rst_i && (r_state == ST_RUN) && bus.rd_en_i;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = bus.wr_addr_i;
    w_mem_wdata = bus.wr_data_i;
    if (!rst_i && (r_state == ST_CLEAR)) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_cnt;
      w_mem_wdata = '0;
    end else if (w_wr_accept) begin
      w_mem_we = 1'b1;
    end
  end

  // No reset on the array: contents survive rst_i unless swept.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read port: stage 1 samples the array (or the bypass), the pipe adds
  // READ_LAT-1 further stages.
  // ---------------------------------------------------------------------
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_word;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              w_pipe_valid;
  logic [DATA_W-1:0] w_pipe_data;
  logic [DATA_W-1:0] r_rd_hold;

  // The array read sees pre-edge contents, which is the old-data ordering
  // for free; write-first needs the incoming word forwarded explicitly.
  assign w_bypass  = (RDW_MODE == RDW_NEW) && w_wr_accept &&
                     (bus.wr_addr_i == bus.rd_addr_i);
  assign w_rd_word = w_bypass ? bus.wr_data_i : r_mem[bus.rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rd_accept) begin
      r_s1_data <= w_rd_word;
    end
  end

  bip_ram_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LAT - 1)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_data),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  // The pipe data flops are not reset and shift every cycle, so the
  // visible read data is held here: it shows the last delivered word and
  // is zero after reset, without adding a cycle of latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_hold <= '0;
    end else if (w_pipe_valid) begin
      r_rd_hold <= w_pipe_data;
    end
  end

  assign bus.rd_valid_o = w_pipe_valid;
  assign bus.rd_data_o  = w_pipe_valid ? w_pipe_data : r_rd_hold;

endmodule

// File: tb/tb_bip_dmem.sv
module tb_bip_dmem;
  import bip_pkg::*;

  // ---------------------------------------------------------------------
  // Clock / reset / shared stimulus
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  // dut_a: 16 words, READ_LAT=3, read-old; dut_b: 16 words, READ_LAT=2,
  // write-first. Both see the same stimulus.
  bip_dmem_if #(.DATA_W(16), .ADDR_W(4)) ifc_a ();
  bip_dmem_if #(.DATA_W(16), .ADDR_W(4)) ifc_b ();

  assign ifc_a.wr_en_i   = wr_en;
  assign ifc_a.wr_addr_i = wr_addr;
  assign ifc_a.wr_data_i = wr_data;
  assign ifc_a.rd_en_i   = rd_en;
  assign ifc_a.rd_addr_i = rd_addr;
  assign ifc_b.wr_en_i   = wr_en;
  assign ifc_b.wr_addr_i = wr_addr;
  assign ifc_b.wr_data_i = wr_data;
  assign ifc_b.rd_en_i   = rd_en;
  assign ifc_b.rd_addr_i = rd_addr;

  state_t dbg_a;
  state_t dbg_b;

  bip_dmem #(
    .DATA_W(16), .ADDR_W(4), .READ_LAT(3), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifc_a), .dbg_state_o(dbg_a)
  );

  bip_dmem #(
    .DATA_W(16), .ADDR_W(4), .READ_LAT(2), .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifc_b), .dbg_state_o(dbg_b)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_va     = 0;
  int n_vb     = 0;
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always @(negedge clk) begin
    if (ifc_a.rd_valid_o) begin
      got_a.push_back(ifc_a.rd_data_o);
      n_va++;
    end
    if (ifc_b.rd_valid_o) begin
      got_b.push_back(ifc_b.rd_data_o);
      n_vb++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_queues(input string tag);
    check_eq({tag, "_cnt_a"}, got_a.size(), exp_a.size());
    check_eq({tag, "_cnt_b"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < got_a.size()) check_eq($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      if (i < got_b.size()) check_eq($sformatf("%s_b%0d", tag, i), got_b[i], exp_b[i]);
    end
    got_a.delete();
    got_b.delete();
    exp_a.delete();
    exp_b.delete();
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  // Counts cycles with busy_o high, starting in the cycle after the last
  // reset edge; bounded so a stuck sweep still reaches the summary.
  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (ifc_a.busy_o && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int c;
    int first_a, first_b;
    int cur_a, cur_b, max_a, max_b;
    int va0, vb0;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_valid_a", ifc_a.rd_valid_o, 0);
    check_eq("rst_data_a",  ifc_a.rd_data_o,  0);
    check_eq("rst_ready_a", ifc_a.ready_o,    0);
    check_eq("rst_busy_a",  ifc_a.busy_o,     1);
    check_eq("rst_valid_b", ifc_b.rd_valid_o, 0);
    check_eq("rst_ready_b", ifc_b.ready_o,    0);
    check_eq("rst_busy_b",  ifc_b.busy_o,     1);
    check_eq("rst_state_a", dbg_a, ST_CLEAR);

    rst = 1'b0;
    wait_sweep(c);
    check_eq("sweep1_len", c, 16);
    check_eq("sweep1_ready_a", ifc_a.ready_o, 1);
    check_eq("sweep1_ready_b", ifc_b.ready_o, 1);

    // Fill with garbage, then reset: the sweep must zero everything
    for (int i = 0; i < 16; i++) write_word(4'(i), 16'hA5A0 | 16'(i));
    rst = 1'b1; tick(); rst = 1'b0;
    wait_sweep(c);
    check_eq("sweep2_len", c, 16);
    check_eq("sweep2_busy_b", ifc_b.busy_o, 0);
    for (int i = 0; i < 16; i++) begin
      read_word(4'(i));
      exp_a.push_back(16'h0000);
      exp_b.push_back(16'h0000);
    end
    repeat (5) tick();
    compare_queues("clear_all");

    // Write then read next cycle; measure latency
    write_word(4'd5, 16'hBEEF);
    rd_en = 1'b1; rd_addr = 4'd5;
    first_a = -1; first_b = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      rd_en = 1'b0;
      if (ifc_a.rd_valid_o && first_a < 0) first_a = k;
      if (ifc_b.rd_valid_o && first_b < 0) first_b = k;
    end
    check_eq("lat_a", first_a, 2);
    check_eq("lat_b", first_b, 1);
    exp_a.push_back(16'hBEEF);
    exp_b.push_back(16'hBEEF);
    compare_queues("beef");

    // Back-to-back reads 0..7
    for (int i = 0; i < 8; i++) write_word(4'(i), 16'h1000 + 16'(i));
    cur_a = 0; cur_b = 0; max_a = 0; max_b = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 8) begin
        rd_en = 1'b1; rd_addr = 4'(k);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      cur_a = ifc_a.rd_valid_o ? cur_a + 1 : 0;
      cur_b = ifc_b.rd_valid_o ? cur_b + 1 : 0;
      if (cur_a > max_a) max_a = cur_a;
      if (cur_b > max_b) max_b = cur_b;
    end
    rd_en = 1'b0;
    check_eq("b2b_run_a", max_a, 8);
    check_eq("b2b_run_b", max_b, 8);
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back(16'h1000 + 16'(i));
      exp_b.push_back(16'h1000 + 16'(i));
    end
    compare_queues("b2b");

    // Same-cycle read/write at one address, then read the cycle after
    write_word(4'd9, 16'hAAAA);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234;
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    repeat (5) tick();
    exp_a.push_back(16'hAAAA); exp_a.push_back(16'h1234);
    exp_b.push_back(16'h1234); exp_b.push_back(16'h1234);
    compare_queues("rdw");

    // Reset with reads in flight. dut_b's first read is taken by the
    // consumer at the reset edge itself; everything later is dropped.
    va0 = n_va; vb0 = n_vb;
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("flight_valid_a", ifc_a.rd_valid_o, 0);
    check_eq("flight_data_a",  ifc_a.rd_data_o,  0);
    check_eq("flight_valid_b", ifc_b.rd_valid_o, 0);
    check_eq("flight_data_b",  ifc_b.rd_data_o,  0);
    rst = 1'b0;
    wait_sweep(c);
    check_eq("sweep3_len", c, 16);
    check_eq("flight_nvalid_a", n_va - va0, 0);
    check_eq("flight_nvalid_b", n_vb - vb0, 1);
    exp_b.push_back(16'h1234);
    compare_queues("flight");

    // Sweep with both strobes held: nothing accepted
    va0 = n_va; vb0 = n_vb;
    rd_en = 1'b1; rd_addr = 4'd2;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep(c);
    rd_en = 1'b0; wr_en = 1'b0;
    check_eq("sweep4_len", c, 16);
    check_eq("strobe_nvalid_a", n_va - va0, 0);
    check_eq("strobe_nvalid_b", n_vb - vb0, 0);
    read_word(4'd2);
    repeat (5) tick();
    exp_a.push_back(16'h0000);
    exp_b.push_back(16'h0000);
    compare_queues("strobe_mem2");

    // Reset at clear address 7 restarts a full sweep
    write_word(4'd12, 16'h5555);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("mid_state_a", dbg_a, ST_CLEAR);
    check_eq("mid_state_b", dbg_b, ST_CLEAR);
    wait_sweep(c);
    check_eq("sweep5_len", c, 16);
    read_word(4'd12);
    repeat (5) tick();
    exp_a.push_back(16'h0000);
    exp_b.push_back(16'h0000);
    compare_queues("mid_mem12");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
